// File: rtl/mlp_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mlp_ctrl_pkg
// Shared types for the MLP controller read path.
//   - rd_state_e : read-sequencer FSM states (IDLE, RUN, DRAIN)
//   - rd_entry_t : one output-buffer entry {data, last}
// MLP_DATAW is the memory word width; the data field of rd_entry_t uses it,
// so mem_stream_reader's DATAW must equal it.
// ----------------------------------------------------------------------------
package mlp_ctrl_pkg;

    localparam int unsigned MLP_DATAW = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

    typedef struct packed {
        logic [MLP_DATAW-1:0] data;
        logic                 last;
    } rd_entry_t;

endpackage

// File: rtl/mem_stream_reader_fifo.sv
// ----------------------------------------------------------------------------
// stream_fifo2
// Two-entry FIFO of rd_entry_t with registered outputs. The head register
// drives the stream directly, so out_valid/head never come from combinational
// logic. Simultaneous push and pop are supported at occupancy 1 or 2.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   push, push_entry  write strobe and entry
//   pop               read strobe (only asserted while out_valid)
//   out_valid         head entry holds data
//   head              current head entry
//   count             occupancy 0..2
// ----------------------------------------------------------------------------
module stream_fifo2
    import mlp_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  rd_entry_t  push_entry,
    input  logic       pop,
    output logic       out_valid,
    output rd_entry_t  head,
    output logic [1:0] count
);

    rd_entry_t head_q;
    rd_entry_t tail_q;
    logic      vld_head;
    logic      vld_tail;

    // Storage stage: tail only ever holds data while head also does.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            vld_head <= 1'b0;
            vld_tail <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (!vld_head) begin
                        head_q   <= push_entry;
                        vld_head <= 1'b1;
                    end else begin
                        tail_q   <= push_entry;
                        vld_tail <= 1'b1;
                    end
                end
                2'b01: begin
                    if (vld_tail) begin
                        head_q   <= tail_q;
                        vld_tail <= 1'b0;
                    end else begin
                        vld_head <= 1'b0;
                    end
                end
                2'b11: begin
                    if (vld_tail) begin
                        head_q <= tail_q;
                        tail_q <= push_entry;
                    end else begin
                        head_q <= push_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = vld_head;
    assign head      = head_q;
    assign count     = vld_tail ? 2'd2 : (vld_head ? 2'd1 : 2'd0);

endmodule

// File: rtl/mem_stream_reader.sv
// ----------------------------------------------------------------------------
// mem_stream_reader
// Read-side sequencer for memory_block: walks start_len words from
// start_addr (wrapping at DEPTH) and turns the memory's one-cycle read
// latency into a valid/ready stream. A read is only issued when the word it
// returns is guaranteed a slot in the 2-entry output buffer.
//
// Optional feature: define MEM_STREAM_READER_STALL_CNT_EN to add the
// stall_cycles output (cycles with out_valid && !out_ready, saturating,
// cleared on accepted start).
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   start, start_addr,       one-cycle request (sampled in IDLE only),
//   start_len                first address, beat count 0..DEPTH
//   busy, done               transfer in progress / one-cycle completion
//   mem_raddr, mem_rdata     memory read address / data (1-cycle latency)
//   out_valid, out_ready,    output stream handshake, payload and
//   out_data, out_last       final-beat marker
//   stall_cycles             (optional) backpressure cycle counter
// ----------------------------------------------------------------------------
module mem_stream_reader
    import mlp_ctrl_pkg::*;
#(
    parameter int unsigned DATAW = MLP_DATAW,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned ADDRW = $clog2(DEPTH),
    parameter int unsigned LENW  = ADDRW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ADDRW-1:0] start_addr,
    input  logic [LENW-1:0]  start_len,
    output logic             busy,
    output logic             done,
    output logic [ADDRW-1:0] mem_raddr,
    input  logic [DATAW-1:0] mem_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DATAW-1:0] out_data,
    output logic             out_last
`ifdef MEM_STREAM_READER_STALL_CNT_EN
   ,output logic [31:0]      stall_cycles
`endif
);

    // Address advance with explicit wrap so non-power-of-2 depths work.
    function automatic logic [ADDRW-1:0] addr_inc(input logic [ADDRW-1:0] a);
        return (a == ADDRW'(DEPTH - 1)) ? '0 : a + 1'b1;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    rd_state_e        state;
    rd_state_e        state_nxt;

    logic [ADDRW-1:0] addr_q;
    logic [ADDRW-1:0] raddr_q;
    logic [LENW-1:0]  remaining_q;
    logic             inflight;
    logic             last_p1;
    logic             done_q;

    logic             accept;
    logic             issue;
    logic             drain_ok;
    logic             pop;
    logic             push;
    logic [1:0]       count;
    logic [2:0]       occ;

    rd_entry_t        push_entry;
    rd_entry_t        head;
    logic             fifo_valid;

    assign pop  = fifo_valid && out_ready;
    assign push = inflight;
    // Slots already spoken for: stored words plus the word returning now.
    assign occ  = {1'b0, count} + {2'b00, inflight};

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (start_len != '0) ? RUN : DRAIN;
                end
            end
            RUN: begin
                if (issue && (remaining_q == LENW'(1))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_ok) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs. The drain test looks one cycle ahead (buffer empties this
    // cycle) so that done lands in the same cycle busy falls.
    always_comb begin
        accept    = (state == IDLE) && start;
        issue     = (state == RUN) && (occ < (3'd2 + {2'b00, pop}));
        drain_ok  = (state == DRAIN) && !inflight &&
                    ((count == 2'd0) || ((count == 2'd1) && pop));
        busy      = (state != IDLE);
        mem_raddr = issue ? addr_q : raddr_q;
    end

    // Issue stage: address/length counters and the in-flight tag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q      <= '0;
            raddr_q     <= '0;
            remaining_q <= '0;
            inflight    <= 1'b0;
            last_p1     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            if (accept) begin
                addr_q      <= start_addr;
                remaining_q <= start_len;
            end else if (issue) begin
                addr_q      <= addr_inc(addr_q);
                raddr_q     <= addr_q;
                remaining_q <= remaining_q - LENW'(1);
            end
            inflight <= issue;
            last_p1  <= issue && (remaining_q == LENW'(1));
            done_q   <= drain_ok;
        end
    end

    assign done = done_q;

    // Return stage: word read last cycle enters the buffer
    always_comb begin
        push_entry      = '0;
        push_entry.data = mem_rdata;
        push_entry.last = last_p1;
    end

    stream_fifo2 u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .out_valid  (fifo_valid),
        .head       (head),
        .count      (count)
    );

    assign out_valid = fifo_valid;
    assign out_data  = head.data;
    // The head keeps its last flag after being popped; mask it when idle.
    assign out_last  = head.last && fifo_valid;

`ifdef MEM_STREAM_READER_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (accept) begin
            stall_q <= '0;
        end else if (fifo_valid && !out_ready) begin
            stall_q <= sat_inc32(stall_q);
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_mem_stream_reader.sv
module tb_mem_stream_reader;

    localparam int DATAW = 128;
    localparam int DEPTH = 64;
    localparam int ADDRW = 6;
    localparam int LENW  = 7;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [ADDRW-1:0] start_addr;
    logic [LENW-1:0]  start_len;
    logic             busy;
    logic             done;
    logic [ADDRW-1:0] mem_raddr;
    logic [DATAW-1:0] mem_rdata;
    logic             out_valid;
    logic             out_ready;
    logic [DATAW-1:0] out_data;
    logic             out_last;
`ifdef MEM_STREAM_READER_STALL_CNT_EN
    logic [31:0]      stall_cycles;
`endif

    logic [DATAW-1:0] mem [DEPTH];

    always #5 clk = ~clk;

    mem_stream_reader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .start_len  (start_len),
        .busy       (busy),
        .done       (done),
        .mem_raddr  (mem_raddr),
        .mem_rdata  (mem_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last)
`ifdef MEM_STREAM_READER_STALL_CNT_EN
       ,.stall_cycles (stall_cycles)
`endif
    );

    // memory_block model: synchronous read, one-cycle latency
    always @(posedge clk) mem_rdata <= mem[mem_raddr];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Buffer must never be pushed while full without a simultaneous pop
    always @(negedge clk) begin
        if (rst === 1'b1 && dut.push && !dut.pop && dut.count == 2'd2)
            check("fifo_overflow", 1, 0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [DATAW-1:0] beats [$];
    logic             lasts [$];
    int               done_cyc;
    int               stalls;

    // Caller is at posedge+1 (cycle 0). Returns at posedge+1 after done.
    task automatic run_stream(input int a, input int len, input int ready_mode,
                              input int second_at, input int limit);
        logic             prev_stall;
        logic [DATAW-1:0] held_d;
        logic             held_l;
        prev_stall = 1'b0;
        held_d     = '0;
        held_l     = 1'b0;
        beats.delete();
        lasts.delete();
        done_cyc = -1;
        stalls   = 0;
        start      = 1'b1;
        start_addr = ADDRW'(a);
        start_len  = LENW'(len);
        out_ready  = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= limit; c++) begin
            out_ready = (ready_mode == 0) ? 1'b1 : ((c % 3) == 1);
            if (second_at == c) begin
                start      = 1'b1;
                start_addr = ADDRW'(40);
                start_len  = LENW'(3);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (prev_stall) begin
                check("stall_hold_valid", out_valid, 1);
                check("stall_hold_data", out_data, held_d);
                check("stall_hold_last", out_last, held_l);
            end
            prev_stall = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    beats.push_back(out_data);
                    lasts.push_back(out_last);
                end else begin
                    stalls++;
                    prev_stall = 1'b1;
                    held_d     = out_data;
                    held_l     = out_last;
                end
            end
            if (done) begin
                done_cyc = c;
                break;
            end
            step();
        end
        start     = 1'b0;
        out_ready = 1'b1;
        step();
    endtask

    task automatic check_stream(input string tag, input int a, input int len, input int exp_done);
        check({tag, "_nbeats"}, beats.size(), len);
        for (int i = 0; i < len && i < beats.size(); i++) begin
            check({tag, "_data"}, beats[i], (a + i) % DEPTH);
            check({tag, "_last"}, lasts[i], (i == len - 1));
        end
        if (exp_done >= 0) check({tag, "_done_cycle"}, done_cyc, exp_done);
        else               check({tag, "_done_seen"}, (done_cyc > 0), 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = DATAW'(i);
        rst        = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        start_len  = '0;
        out_ready  = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_data", out_data, 0);
        check("rst_raddr", mem_raddr, 0);
        step();
        rst = 1'b1;
        step();

        // Cycle-exact 8-beat transfer from address 4
        start      = 1'b1;
        start_addr = 6'd4;
        start_len  = 7'd8;
        step();
        start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            check("t1_busy", busy, (c >= 1 && c <= 10));
            check("t1_done", done, (c == 11));
            check("t1_valid", out_valid, (c >= 3 && c <= 10));
            if (c >= 3 && c <= 10) begin
                check("t1_data", out_data, 4 + c - 3);
                check("t1_last", out_last, (c == 10));
            end
            step();
        end

        // Address wrap 62,63,0,1
        run_stream(62, 4, 0, 0, 30);
        check_stream("wrap", 62, 4, 7);

        // Backpressure pattern 1,0,0 over 16 beats
        run_stream(20, 16, 1, 0, 200);
        check_stream("stall", 20, 16, -1);
`ifdef MEM_STREAM_READER_STALL_CNT_EN
        check("stall_cycles", stall_cycles, stalls);
`endif

        // Zero-length request
        start      = 1'b1;
        start_addr = 6'd5;
        start_len  = 7'd0;
        step();
        start = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check("zero_done", done, (c == 2));
            check("zero_valid", out_valid, 0);
            check("zero_busy", busy, (c == 1));
            step();
        end

        // Second start while busy is ignored
        run_stream(10, 6, 0, 2, 30);
        check_stream("ignored", 10, 6, 9);

        // Asynchronous reset after three beats
        start      = 1'b1;
        start_addr = 6'd30;
        start_len  = 7'd10;
        out_ready  = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c < 5) step();
        end
        check("mid_beat3_data", out_data, 32);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_last", out_last, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_raddr", mem_raddr, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("mid_rst_no_done", done, 0);
        end
        step();
        rst = 1'b1;
        step();
        run_stream(50, 5, 0, 0, 30);
        check_stream("after_rst", 50, 5, 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
